// File: rtl/fabric_boot_pkg.sv
// rtl/fabric_boot_pkg.sv - shared state/source types for the fabric boot sequencer
package fabric_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_WAIT_CFG,
    ST_DONE,
    ST_RETRY,
    ST_FAIL,
    ST_RX
  } boot_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_CTRL,
    SRC_RX
  } src_sel_e;

  function automatic src_sel_e src_for_state(boot_state_e st);
    case (st)
      ST_LOAD: return SRC_CTRL;
      ST_RX:   return SRC_RX;
      default: return SRC_NONE;
    endcase
  endfunction

  function automatic logic is_busy_state(boot_state_e st);
    return (st == ST_START) || (st == ST_LOAD) || (st == ST_WAIT_CFG) || (st == ST_RETRY);
  endfunction

endpackage

// File: rtl/fabric_boot_sequencer_if.sv
// rtl/fabric_boot_sequencer_if.sv - controller, receiver and fabric_config bus of the boot sequencer
interface fabric_boot_sequencer_if #(
  parameter int SLOT_W = 4
);
  logic              ctrl_start_o;
  logic [SLOT_W-1:0] ctrl_slot_o;
  logic              ctrl_busy_i;
  logic [31:0]       ctrl_data_i;
  logic              ctrl_valid_i;
  logic [31:0]       rx_data_i;
  logic              rx_valid_i;
  logic [31:0]       cfg_data_o;
  logic              cfg_valid_o;
  logic              cfg_busy_i;
  logic              cfg_configured_i;

  modport master (
    output ctrl_start_o, ctrl_slot_o, cfg_data_o, cfg_valid_o,
    input  ctrl_busy_i, ctrl_data_i, ctrl_valid_i, rx_data_i, rx_valid_i,
    input  cfg_busy_i, cfg_configured_i
  );

  modport slave (
    input  ctrl_start_o, ctrl_slot_o, cfg_data_o, cfg_valid_o,
    output ctrl_busy_i, ctrl_data_i, ctrl_valid_i, rx_data_i, rx_valid_i,
    output cfg_busy_i, cfg_configured_i
  );
endinterface

// File: rtl/fabric_boot_timeout.sv
// rtl/fabric_boot_timeout.sv - clearable saturating load timeout counter
module fabric_boot_timeout #(
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the enabled cycle in which the count reaches TIMEOUT_CYCLES.
  assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/fabric_boot_sequencer.sv
// rtl/fabric_boot_sequencer.sv - boot/warmboot sequencing, retry/golden fallback and bitstream mux
module fabric_boot_sequencer
  import fabric_boot_pkg::*;
#(
  parameter int NUM_SLOTS      = 16,
  parameter int SLOT_W         = 4,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mode_i,
  input  logic                    warmboot_boot_i,
  input  logic [SLOT_W-1:0]       warmboot_slot_i,
  fabric_boot_sequencer_if.master bus,
  output logic                    fabric_hold_o,
  output logic                    busy_o,
  output logic                    error_o,
  output logic [SLOT_W-1:0]       active_slot_o
);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  boot_state_e       state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [RW-1:0]     retry_q, retry_d, retry_inc;
  logic              seen_busy_q, seen_busy_d;
  logic              error_q, error_d;
  logic              wb_prev_q;
  logic              ctrl_start_q;
  logic [SLOT_W-1:0] ctrl_slot_q;
  logic [SLOT_W-1:0] active_slot_q;
  logic [31:0]       cfg_data_q;
  logic              cfg_valid_q;
  logic              hold_q, hold_d;
  logic              busy_q;

  logic              wb_edge;
  logic              slot_ok;
  logic              tmo_expired;
  logic              fwd_valid;
  logic [31:0]       fwd_data;

  assign wb_edge   = warmboot_boot_i && !wb_prev_q;
  assign slot_ok   = int'(warmboot_slot_i) < NUM_SLOTS;
  assign retry_inc = retry_q + 1'b1;

  fabric_boot_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == ST_START),
    .en_i     ((state_q == ST_LOAD) || (state_q == ST_WAIT_CFG)),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    retry_d     = retry_q;
    seen_busy_d = seen_busy_q;
    error_d     = error_q;
    case (state_q)
      ST_IDLE: begin
        if (mode_i) begin
          state_d = ST_RX;
        end else begin
          state_d = ST_START;
          slot_d  = '0;
          retry_d = '0;
        end
      end
      ST_START: begin
        state_d     = ST_LOAD;
        seen_busy_d = 1'b0;
      end
      ST_LOAD: begin
        // The load is over only after the controller has actually been seen busy.
        if (bus.ctrl_busy_i) seen_busy_d = 1'b1;
        if (seen_busy_q && !bus.ctrl_busy_i) begin
          state_d = ST_WAIT_CFG;
        end else if (tmo_expired) begin
          state_d = ST_RETRY;
        end
      end
      ST_WAIT_CFG: begin
        if (!bus.cfg_busy_i) begin
          state_d = bus.cfg_configured_i ? ST_DONE : ST_RETRY;
        end else if (tmo_expired) begin
          state_d = ST_RETRY;
        end
      end
      ST_RETRY: begin
        retry_d = retry_inc;
        if (int'(retry_inc) < MAX_RETRIES) begin
          state_d = ST_START;
        end else if (slot_q != '0) begin
          state_d = ST_START;
          slot_d  = '0;
          retry_d = '0;
        end else begin
          state_d = ST_FAIL;
          error_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (mode_i) begin
          state_d = ST_RX;
        end else if (wb_edge) begin
          if (slot_ok) begin
            state_d = ST_START;
            slot_d  = warmboot_slot_i;
            retry_d = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_FAIL: begin
        error_d = 1'b1;
        if (mode_i) state_d = ST_RX;
      end
      ST_RX: begin
        if (!mode_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fwd_valid = 1'b0;
    fwd_data  = 32'h0;
    case (src_for_state(state_q))
      SRC_CTRL: begin
        fwd_valid = bus.ctrl_valid_i;
        fwd_data  = bus.ctrl_data_i;
      end
      SRC_RX: begin
        fwd_valid = bus.rx_valid_i;
        fwd_data  = bus.rx_data_i;
      end
      default: begin
        fwd_valid = 1'b0;
        fwd_data  = 32'h0;
      end
    endcase
  end

  // Hold follows the next state so it rises on the very edge that leaves DONE.
  always_comb begin
    hold_d = 1'b1;
    if (state_d == ST_DONE) begin
      hold_d = 1'b0;
    end else if ((state_d == ST_RX) && bus.cfg_configured_i && !bus.cfg_busy_i) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      slot_q        <= '0;
      retry_q       <= '0;
      seen_busy_q   <= 1'b0;
      error_q       <= 1'b0;
      wb_prev_q     <= 1'b0;
      ctrl_start_q  <= 1'b0;
      ctrl_slot_q   <= '0;
      active_slot_q <= '0;
      cfg_data_q    <= 32'h0;
      cfg_valid_q   <= 1'b0;
      hold_q        <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      retry_q      <= retry_d;
      seen_busy_q  <= seen_busy_d;
      error_q      <= error_d;
      wb_prev_q    <= warmboot_boot_i;
      ctrl_start_q <= (state_q == ST_START);
      if (state_q == ST_START) begin
        ctrl_slot_q   <= slot_q;
        active_slot_q <= slot_q;
      end
      cfg_valid_q <= fwd_valid;
      if (fwd_valid) cfg_data_q <= fwd_data;
      hold_q <= hold_d;
      busy_q <= is_busy_state(state_d);
    end
  end

  assign bus.ctrl_start_o = ctrl_start_q;
  assign bus.ctrl_slot_o  = ctrl_slot_q;
  assign bus.cfg_data_o   = cfg_data_q;
  assign bus.cfg_valid_o  = cfg_valid_q;
  assign fabric_hold_o    = hold_q;
  assign busy_o           = busy_q;
  assign error_o          = error_q;
  assign active_slot_o    = active_slot_q;

endmodule

// File: tb/tb_fabric_boot_sequencer.sv
// tb/tb_fabric_boot_sequencer.sv - randomized self-checking bench for fabric_boot_sequencer
module tb_fabric_boot_sequencer;
  localparam int NSLOTS = 8;
  localparam int SLOT_W = 4;
  localparam int TMO    = 64;
  localparam int MAXR   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mode = 1'b0;
  logic              wb_boot = 1'b0;
  logic [SLOT_W-1:0] wb_slot = '0;
  logic              hold, busy, err;
  logic [SLOT_W-1:0] act_slot;

  fabric_boot_sequencer_if #(.SLOT_W(SLOT_W)) bus ();

  fabric_boot_sequencer #(
    .NUM_SLOTS(NSLOTS), .SLOT_W(SLOT_W), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode),
    .warmboot_boot_i(wb_boot), .warmboot_slot_i(wb_slot),
    .bus(bus.master),
    .fabric_hold_o(hold), .busy_o(busy), .error_o(err), .active_slot_o(act_slot)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          exp_err = 1'b0;
  int          start_cyc_q[$];
  int          start_slot_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_cyc_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One cycle: advance to the falling edge, record start pulses, score forwarded words.
  task automatic tick();
    logic [31:0] d;
    int t;
    @(negedge clk);
    cyc++;
    if (bus.ctrl_start_o) begin
      start_cyc_q.push_back(cyc);
      start_slot_q.push_back(int'(bus.ctrl_slot_o));
    end
    if (bus.cfg_valid_o) begin
      if (exp_data_q.size() == 0) begin
        check_eq("stray_word", 1, 0);
      end else begin
        d = exp_data_q.pop_front();
        t = exp_cyc_q.pop_front();
        check_eq("word_data", bus.cfg_data_o, d);
        check_eq("word_latency", cyc, t);
      end
    end
  endtask

  task automatic await_start(output int c, output int s, output bit got);
    got = 1'b0; c = 0; s = 0;
    for (int i = 0; i < 300 && start_cyc_q.size() == 0; i++) tick();
    if (start_cyc_q.size() != 0) begin
      got = 1'b1;
      c = start_cyc_q.pop_front();
      s = start_slot_q.pop_front();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_start"}, bus.ctrl_start_o, 0);
    check_eq({tag, "_cfg_valid"}, bus.cfg_valid_o, 0);
    check_eq({tag, "_cfg_data"}, bus.cfg_data_o, 0);
    check_eq({tag, "_ctrl_slot"}, bus.ctrl_slot_o, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_error"}, err, 0);
    check_eq({tag, "_active"}, act_slot, 0);
    check_eq({tag, "_hold"}, hold, 1);
  endtask

  // One controller load attempt: random busy length and words, then fabric_config verdict.
  task automatic run_attempt(input int exp_slot, input bit ok, input int exp_cyc);
    int c, s, nb, nc;
    bit got;
    logic [31:0] d;
    await_start(c, s, got);
    check_eq("start_seen", got, 1);
    if (!got) return;
    check_eq("start_slot", s, exp_slot);
    if (exp_cyc >= 0) check_eq("start_cycle", c, exp_cyc);
    check_eq("active_slot", act_slot, exp_slot);
    check_eq("busy_in_load", busy, 1);
    check_eq("hold_in_load", hold, 1);
    nb = $urandom_range(5, 25);
    bus.ctrl_busy_i = 1'b1;
    for (int i = 0; i < nb; i++) begin
      bus.ctrl_valid_i = 1'($urandom_range(0, 1));
      if (bus.ctrl_valid_i) begin
        d = $urandom;
        bus.ctrl_data_i = d;
        exp_data_q.push_back(d);
        exp_cyc_q.push_back(cyc + 1);
      end
      bus.rx_valid_i = 1'($urandom_range(0, 1));
      bus.rx_data_i  = $urandom;
      tick();
    end
    bus.ctrl_valid_i     = 1'b0;
    bus.rx_valid_i       = 1'b0;
    bus.ctrl_busy_i      = 1'b0;
    bus.cfg_busy_i       = 1'b1;
    bus.cfg_configured_i = 1'b0;
    nc = $urandom_range(1, 8);
    repeat (nc) tick();
    bus.cfg_busy_i       = 1'b0;
    bus.cfg_configured_i = ok;
    tick();
    tick();
    if (ok) begin
      check_eq("hold_done", hold, 0);
      check_eq("busy_done", busy, 0);
      check_eq("error_done", err, exp_err);
    end
  endtask

  // Warmboot from DONE; attempts failing nfail times follow the retry/golden rules.
  task automatic warm_seq(input int slot, input int nfail);
    int n;
    wb_slot = SLOT_W'(slot);
    wb_boot = 1'b1;
    n = cyc;
    tick();
    wb_boot = 1'b0;
    if (slot >= NSLOTS) begin
      repeat (10) tick();
      exp_err = 1'b1;
      check_eq("illegal_no_start", start_cyc_q.size(), 0);
      check_eq("illegal_error", err, 1);
      check_eq("illegal_hold", hold, 0);
    end else begin
      check_eq("hold_leave_done", hold, 1);
      for (int a = 0; a <= nfail; a++)
        run_attempt((a < MAXR) ? slot : 0, a == nfail, (a == 0) ? n + 2 : -1);
    end
  endtask

  initial begin
    int r, c, s, prev, m;
    bit got;
    logic [31:0] d;
    bus.ctrl_busy_i = 1'b0;
    bus.ctrl_data_i = '0;
    bus.ctrl_valid_i = 1'b0;
    bus.rx_data_i = '0;
    bus.rx_valid_i = 1'b0;
    bus.cfg_busy_i = 1'b0;
    bus.cfg_configured_i = 1'b0;

    repeat (3) tick();
    check_reset_vals("por");
    rst = 1'b0;
    r = cyc;
    run_attempt(0, 1'b1, r + 2);

    for (int i = 0; i < 6; i++) begin
      bus.ctrl_valid_i = 1'b1; bus.ctrl_data_i = $urandom;
      bus.rx_valid_i = 1'b1;   bus.rx_data_i = $urandom;
      tick();
    end
    bus.ctrl_valid_i = 1'b0; bus.rx_valid_i = 1'b0;
    tick(); tick();

    repeat (3) warm_seq($urandom_range(1, NSLOTS - 1), 0);
    warm_seq(7, 3);
    warm_seq($urandom_range(1, NSLOTS - 1), $urandom_range(1, 4));
    warm_seq($urandom_range(NSLOTS, 15), 0);

    mode = 1'b1;
    tick(); tick();
    check_eq("rx_busy", busy, 0);
    for (int i = 0; i < 12; i++) begin
      bus.rx_valid_i = 1'($urandom_range(0, 1));
      if (bus.rx_valid_i) begin
        d = $urandom;
        bus.rx_data_i = d;
        exp_data_q.push_back(d);
        exp_cyc_q.push_back(cyc + 1);
      end
      bus.ctrl_valid_i = 1'($urandom_range(0, 1));
      bus.ctrl_data_i  = $urandom;
      tick();
    end
    bus.rx_valid_i = 1'b0; bus.ctrl_valid_i = 1'b0;
    bus.cfg_busy_i = 1'b0; bus.cfg_configured_i = 1'b0;
    tick(); tick();
    check_eq("rx_hold_unconfigured", hold, 1);
    bus.cfg_configured_i = 1'b1;
    tick(); tick();
    check_eq("rx_hold_configured", hold, 0);
    mode = 1'b0;
    m = cyc;
    run_attempt(0, 1'b1, m + 3);

    wb_slot = SLOT_W'($urandom_range(1, NSLOTS - 1));
    wb_boot = 1'b1;
    tick();
    wb_boot = 1'b0;
    await_start(c, s, got);
    check_eq("midload_start", got, 1);
    bus.ctrl_busy_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      bus.ctrl_valid_i = 1'b1;
      bus.ctrl_data_i = d;
      exp_data_q.push_back(d);
      exp_cyc_q.push_back(cyc + 1);
      tick();
    end
    rst = 1'b1;
    bus.ctrl_data_i = $urandom;
    tick();
    check_reset_vals("midload_rst");
    tick();
    check_reset_vals("midload_rst2");
    bus.ctrl_valid_i = 1'b0; bus.ctrl_busy_i = 1'b0;
    rst = 1'b0;
    exp_err = 1'b0;
    r = cyc;
    run_attempt(0, 1'b1, r + 2);

    rst = 1'b1;
    tick(); tick();
    check_reset_vals("tmo_rst");
    bus.ctrl_busy_i = 1'b1;
    rst = 1'b0;
    r = cyc;
    prev = 0;
    for (int a = 0; a < MAXR; a++) begin
      await_start(c, s, got);
      check_eq("tmo_start_seen", got, 1);
      check_eq("tmo_start_slot", s, 0);
      if (a == 0) check_eq("tmo_first_start", c, r + 2);
      else check_eq("tmo_period", c - prev, TMO + 2);
      prev = c;
    end
    repeat (150) tick();
    check_eq("fail_no_restart", start_cyc_q.size(), 0);
    check_eq("fail_error", err, 1);
    check_eq("fail_hold", hold, 1);
    check_eq("fail_busy", busy, 0);
    bus.ctrl_busy_i = 1'b0;

    check_eq("words_drained", exp_data_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
